// File: rtl/r_return_mux.sv
// r_return_mux
//   Return path for a two-slave AXI read fabric. R-channel beats from S0 or S1
//   are routed back to the single master. Reads that decode to neither slave
//   are answered locally with DECERR bursts. Only one read may be outstanding
//   at a time. AR_EN tells the AR address decoder when it may forward ARVALID
//   to a slave.
//
// Ports
//   ACLK, ARESET                 clock, synchronous active-high reset
//   ARID_M/ARADDR_M/ARLEN_M      master AR payload
//   ARVALID_M / ARREADY_M        master AR handshake
//   ARREADY_S0 / ARREADY_S1      slave AR ready, used to build ARREADY_M
//   AR_EN                        1 = decoder may drive ARVALID_S0/S1
//   R*_S0, R*_S1                 slave R channels (RREADY_Sx is an output)
//   R*_M                         master R channel (RREADY_M is an input)
module r_return_mux #(
  parameter int ID_W = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W = 4,
  parameter logic [ADDR_W-1:0] S0_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] S0_LAST = 32'h0000_FFFF,
  parameter logic [ADDR_W-1:0] S1_BASE = 32'h0001_0000,
  parameter logic [ADDR_W-1:0] S1_LAST = 32'h0001_FFFF
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   ARID_M,
  input  logic [ADDR_W-1:0] ARADDR_M,
  input  logic [LEN_W-1:0]  ARLEN_M,
  input  logic              ARVALID_M,
  output logic              ARREADY_M,
  input  logic              ARREADY_S0,
  input  logic              ARREADY_S1,
  output logic              AR_EN,
  input  logic [ID_W-1:0]   RID_S0,
  input  logic [DATA_W-1:0] RDATA_S0,
  input  logic [1:0]        RRESP_S0,
  input  logic              RLAST_S0,
  input  logic              RVALID_S0,
  output logic              RREADY_S0,
  input  logic [ID_W-1:0]   RID_S1,
  input  logic [DATA_W-1:0] RDATA_S1,
  input  logic [1:0]        RRESP_S1,
  input  logic              RLAST_S1,
  input  logic              RVALID_S1,
  output logic              RREADY_S1,
  output logic [ID_W-1:0]   RID_M,
  output logic [DATA_W-1:0] RDATA_M,
  output logic [1:0]        RRESP_M,
  output logic              RLAST_M,
  output logic              RVALID_M,
  input  logic              RREADY_M
);

  typedef enum logic [1:0] {IDLE, RD_S0, RD_S1, RD_DEC} state_t;

  state_t            state_p1, state_nxt;
  logic [LEN_W-1:0]  cnt_p1, cnt_nxt;
  logic [LEN_W-1:0]  len_p1;
  logic [ID_W-1:0]   id_p1;

  logic [ADDR_W-1:0] off_s0, off_s1;
  logic              hit_s0, hit_s1;
  logic              arready_dec;
  logic              ar_hs;
  logic              dec_last;

  // Address decode: one wrapping subtraction gives an inclusive range test
  // without a compare against zero when a window starts at address 0.
  assign off_s0 = ARADDR_M - S0_BASE;
  assign off_s1 = ARADDR_M - S1_BASE;
  assign hit_s0 = (off_s0 <= (S0_LAST - S0_BASE));
  assign hit_s1 = !hit_s0 && (off_s1 <= (S1_LAST - S1_BASE));

  // Unmapped reads are accepted immediately: this block is their slave.
  always_comb begin
    arready_dec = 1'b1;
    if (hit_s0) begin
      arready_dec = ARREADY_S0;
    end else if (hit_s1) begin
      arready_dec = ARREADY_S1;
    end
  end

  assign ar_hs    = (state_p1 == IDLE) && ARVALID_M && arready_dec;
  assign dec_last = (cnt_p1 == len_p1);

  always_comb begin
    state_nxt = state_p1;
    cnt_nxt   = cnt_p1;
    case (state_p1)
      IDLE: begin
        cnt_nxt = '0;
        if (ar_hs) begin
          if (hit_s0) begin
            state_nxt = RD_S0;
          end else if (hit_s1) begin
            state_nxt = RD_S1;
          end else begin
            state_nxt = RD_DEC;
          end
        end
      end
      // Slave RLAST alone ends a routed burst; beat count is not checked.
      RD_S0: begin
        if (RVALID_S0 && RREADY_M && RLAST_S0) state_nxt = IDLE;
      end
      RD_S1: begin
        if (RVALID_S1 && RREADY_M && RLAST_S1) state_nxt = IDLE;
      end
      // RVALID_M is always high here, so RREADY_M alone accepts a beat.
      RD_DEC: begin
        if (RREADY_M) begin
          if (dec_last) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt_p1 + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage boundary: burst state, beat counter and latched AR fields.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_p1 <= IDLE;
      cnt_p1   <= '0;
      id_p1    <= '0;
      len_p1   <= '0;
    end else begin
      state_p1 <= state_nxt;
      cnt_p1   <= cnt_nxt;
      if (ar_hs) begin
        id_p1  <= ARID_M;
        len_p1 <= ARLEN_M;
      end
    end
  end

  // Outputs are forced to zero during the reset cycle, whatever the state.
  always_comb begin
    ARREADY_M = 1'b0;
    AR_EN     = 1'b0;
    RREADY_S0 = 1'b0;
    RREADY_S1 = 1'b0;
    RID_M     = '0;
    RDATA_M   = '0;
    RRESP_M   = 2'b00;
    RLAST_M   = 1'b0;
    RVALID_M  = 1'b0;
    if (!ARESET) begin
      case (state_p1)
        IDLE: begin
          AR_EN     = 1'b1;
          ARREADY_M = arready_dec;
        end
        RD_S0: begin
          RID_M     = RID_S0;
          RDATA_M   = RDATA_S0;
          RRESP_M   = RRESP_S0;
          RLAST_M   = RLAST_S0;
          RVALID_M  = RVALID_S0;
          RREADY_S0 = RREADY_M;
        end
        RD_S1: begin
          RID_M     = RID_S1;
          RDATA_M   = RDATA_S1;
          RRESP_M   = RRESP_S1;
          RLAST_M   = RLAST_S1;
          RVALID_M  = RVALID_S1;
          RREADY_S1 = RREADY_M;
        end
        RD_DEC: begin
          RID_M     = id_p1;
          RRESP_M   = 2'b11;
          RLAST_M   = dec_last;
          RVALID_M  = 1'b1;
        end
        default: begin
          AR_EN = 1'b0;
        end
      endcase
    end
  end

endmodule
